perm_tag_realign: RTL
=====================

Name: perm_tag_realign

Overview:
- Parametrised successor to the fixed 27-stage column-order delay line and X rearrange stage at the detector top level.
- Decomposition emits one column permutation per channel instance; this block queues those permutations in a tag FIFO.
- Each detector output vector is popped against the oldest queued permutation and scattered back to the original antenna order.
- Detector latency becomes variable and need not be hard-coded; the block adds occupancy reporting, error flags and a bypass mode.

Parameters:
N_COL, 8, number of columns/symbols per vector
IDX_W, 3, bits per permutation index; require 2^IDX_W >= N_COL
SYM_W, 2, bits per detected symbol
DEPTH, 32, tag FIFO entries; must be >= maximum detector latency in vectors
CNT_W, 6, occupancy counter width = clog2(DEPTH+1)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
perm_valid  in  1  perm_i valid this cycle (decomposition output strobe)
perm_i  in  N_COL*IDX_W  column order; field k = original column of sorted column k
det_valid  in  1  detector output valid this cycle
x_i  in  N_COL*SYM_W  detector symbols in sorted order; field k = sorted column k
bypass  in  1  1 = ignore the popped permutation and use identity
clr_err  in  1  clears sticky error flags
x_o  out  N_COL*SYM_W  symbols in original column order
x_valid  out  1  x_o valid
occupancy  out  CNT_W  FIFO entry count
err_overflow  out  1  sticky: push attempted while full
err_underflow  out  1  sticky: pop attempted with no permutation available
err_perm  out  1  sticky: pushed permutation had a duplicate or out-of-range index

Behaviour:
- Reset (clk edge with rst=1):
  - FIFO pointers and occupancy go to 0.
  - x_o = 0, x_valid = 0, all err_* = 0.
  - Reset mid-operation discards every queued permutation; a det_valid in the reset cycle is ignored.
- FIFO storage: circular buffer, DEPTH entries, read/write pointers wrap modulo DEPTH, separate occupancy counter. Non-power-of-2 DEPTH is supported.
- Push (perm_valid=1):
  - If not full, write at wptr and advance it.
  - If full and no pop this cycle, drop the permutation and set err_overflow.
  - If full with a simultaneous pop, accept the push; occupancy is unchanged.
- Pop (det_valid=1):
  - Permutation source is the FIFO head when occupancy>0.
  - If occupancy==0 and perm_valid=1 in the same cycle, perm_i is used directly (fall-through); nothing is stored and occupancy stays 0.
  - If occupancy==0 and perm_valid=0, use identity, set err_underflow, and still emit output.
- Simultaneous push and pop, occupancy>0: pop the head, push perm_i; occupancy is unchanged.
- Rearrange, combinational on the selected permutation p:
  - For each k, x_o field p[k] = x_i field k.
  - Destination slots not written by any k are 0.
  - If several k hit the same slot, the highest k wins.
  - With bypass=1, p = identity; bypass does not affect popping.
- Output register:
  - x_o and x_valid update one clock after det_valid (latency 1).
  - x_valid=0 in any cycle following det_valid=0; x_o holds its last value.
- Permutation check at push:
  - If perm_i has a repeated field, or any field >= N_COL, set err_perm.
  - The permutation is still stored if space allows.
- Error flags:
  - Sticky until clr_err=1, which clears all three next cycle.
  - A new error event in the same cycle as clr_err takes priority (flag stays 1).
- occupancy: registered; reflects the post-update count each cycle.
- No backpressure: the detector is free-running; the consumer must accept x_o every x_valid cycle.

Test Plan:
- Reset, then push perm {7,6,5,4,3,2,1,0} (field k = 7-k); 27 cycles later det_valid with x_i fields {0,1,2,3,0,1,2,3} -> next cycle x_valid=1, x_o fields {3,2,1,0,3,2,1,0}; occupancy 1->0; no errors.
- Push 32 distinct permutations with no pops -> occupancy=32. 33rd push -> err_overflow=1, occupancy stays 32. Then 32 pops return the permutations in push order, including across the pointer wrap.
- occupancy=0 with perm_valid and det_valid in the same cycle, perm = identity rotated by 1 -> x_o is x_i scattered by that rotation; err_underflow=0; occupancy stays 0.
- det_valid with an empty FIFO and no push -> x_o = x_i (identity), err_underflow=1. Then clr_err=1 -> all flags 0 the following cycle.
- Push perm with fields 0 and 1 both equal to 2 -> err_perm=1. On pop, slot 2 = x_i field 1 (highest k wins), slot 0 = 0.
- bypass=1 with a non-identity head -> x_o = x_i and occupancy decrements. Assert rst with 5 entries queued -> occupancy=0, x_valid=0, x_o=0 next cycle.

Source files
------------

// File: rtl/perm_tag_realign.sv
`default_nettype none
// ============================================================================
// Module   : perm_tag_realign
// Purpose  : Queues column permutations and scatters each detector output back
//            to the original antenna order.
// Revision : 1.0
// ============================================================================
module perm_tag_realign #(
  parameter int N_COL = 8,
  parameter int IDX_W = 3,
  parameter int SYM_W = 2,
  parameter int DEPTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   perm_valid,
  input  logic [N_COL*IDX_W-1:0] perm_i,
  input  logic                   det_valid,
  input  logic [N_COL*SYM_W-1:0] x_i,
  input  logic                   bypass,
  input  logic                   clr_err,
  output logic [N_COL*SYM_W-1:0] x_o,
  output logic                   x_valid,
  output logic [CNT_W-1:0]       occupancy,
  output logic                   err_overflow,
  output logic                   err_underflow,
  output logic                   err_perm
);

  localparam int C_PW    = N_COL * IDX_W;
  localparam int C_XW    = N_COL * SYM_W;
  localparam int C_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [C_PW-1:0]    r_mem [DEPTH];
  logic [C_PTR_W-1:0] r_wptr;
  logic [C_PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0]   r_occ;

  logic [C_PW-1:0] w_ident;
  logic [C_PW-1:0] w_sel;
  logic [C_XW-1:0] w_x_sc;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_fall;
  logic            w_under;
  logic            w_push;
  logic            w_over;
  logic            w_perm_bad;

  for (genvar k = 0; k < N_COL; k++) begin : g_ident
    assign w_ident[k*IDX_W +: IDX_W] = IDX_W'(k);
  end

  assign w_empty = (r_occ == '0);
  assign w_full  = (r_occ == CNT_W'(DEPTH));
  assign w_pop   = det_valid && !w_empty;
  assign w_fall  = det_valid && w_empty && perm_valid;
  assign w_under = det_valid && w_empty && !perm_valid;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push  = perm_valid && !w_fall && (!w_full || w_pop);
  assign w_over  = perm_valid && w_full && !det_valid;

  always_comb begin
    w_perm_bad = 1'b0;
    for (int i = 0; i < N_COL; i++) begin
      if (int'(perm_i[i*IDX_W +: IDX_W]) >= N_COL) w_perm_bad = 1'b1;
      for (int j = i + 1; j < N_COL; j++) begin
        if (perm_i[i*IDX_W +: IDX_W] == perm_i[j*IDX_W +: IDX_W]) w_perm_bad = 1'b1;
      end
    end
  end

  always_comb begin
    if (bypass || w_under) w_sel = w_ident;
    else if (w_pop)        w_sel = r_mem[r_rptr];
    else                   w_sel = perm_i;
  end

  // Ascending k order makes the highest colliding source win a slot.
  always_comb begin
    w_x_sc = '0;
    for (int k = 0; k < N_COL; k++) begin
      if (int'(w_sel[k*IDX_W +: IDX_W]) < N_COL)
        w_x_sc[int'(w_sel[k*IDX_W +: IDX_W])*SYM_W +: SYM_W] = x_i[k*SYM_W +: SYM_W];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !rst) r_mem[r_wptr] <= perm_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_occ         <= '0;
      x_o           <= '0;
      x_valid       <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_perm      <= 1'b0;
    end else begin
      if (w_push)
        r_wptr <= (r_wptr == C_PTR_W'(DEPTH - 1)) ? '0 : r_wptr + C_PTR_W'(1);
      if (w_pop)
        r_rptr <= (r_rptr == C_PTR_W'(DEPTH - 1)) ? '0 : r_rptr + C_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + CNT_W'(1);
        2'b01:   r_occ <= r_occ - CNT_W'(1);
        default: r_occ <= r_occ;
      endcase
      x_valid <= det_valid;
      if (det_valid) x_o <= w_x_sc;
      err_overflow  <= (err_overflow  && !clr_err) || w_over;
      err_underflow <= (err_underflow && !clr_err) || w_under;
      err_perm      <= (err_perm      && !clr_err) || (perm_valid && w_perm_bad);
    end
  end

  assign occupancy = r_occ;

endmodule
`default_nettype wire
